// File: rtl/pid_controller_mc_if.sv
// Bus bundle for the multi-channel PID controller: per-channel setpoints/positions/modes,
// shared gains and limits in, packed duties plus the sweep strobes out.
interface pid_controller_mc_if #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] setpoint;
  logic [CHANNELS*WIDTH-1:0] state;
  logic [CHANNELS*2-1:0]     mode;
  logic signed [WIDTH-1:0]   Kp;
  logic signed [WIDTH-1:0]   Ki;
  logic signed [WIDTH-1:0]   Kd;
  logic signed [WIDTH-1:0]   PWMLimit;
  logic signed [WIDTH-1:0]   IntegralLimit;
  logic signed [WIDTH-1:0]   deadband;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      duty_valid;
  logic                      busy;

  modport master (
    output setpoint, state, mode, Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband,
    input  duty, duty_valid, busy
  );

  modport slave (
    input  setpoint, state, mode, Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband,
    output duty, duty_valid, busy
  );
endinterface

// File: rtl/pid_controller_mc.sv
// Time-multiplexed PID controller: a rate divider ticks a sweep in which one shared
// multiplier computes Kp*e + Ki*I + Kd*d for each channel in turn (5 cycles per channel).
module pid_controller_mc #(
  parameter int WIDTH        = 24,
  parameter int CHANNELS     = 4,
  parameter int CLOCK_FREQ   = 16_000_000,
  parameter int CONTROL_FREQ = 1000,
  parameter int ERR_SHIFT    = 4,
  parameter int GAIN_SHIFT   = 0
) (
  input  logic               CLK,
  input  logic               reset_n,
  pid_controller_mc_if.slave bus
);
  localparam int TICK_DIV = CLOCK_FREQ / CONTROL_FREQ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int W1       = WIDTH + 1;
  localparam int AW       = 2 * WIDTH + 2;

  // A tick must never land while a sweep is still running.
  generate
    if (TICK_DIV < 5 * CHANNELS + 2) begin : g_tick_too_fast
      $error("pid_controller_mc: TICK_DIV too small for CHANNELS");
    end
  endgenerate

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [W1-1:0] v);
    if (v > $signed({2'b00, {(WIDTH-1){1'b1}}}))
      sat_w = $signed({1'b0, {(WIDTH-1){1'b1}}});
    else if (v < $signed({2'b11, {(WIDTH-1){1'b0}}}))
      sat_w = $signed({1'b1, {(WIDTH-1){1'b0}}});
    else
      sat_w = v[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] non_neg(input logic signed [WIDTH-1:0] v);
    non_neg = v[WIDTH-1] ? $signed({WIDTH{1'b0}}) : v;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0, S_ERR = 3'd1, S_MUL_P = 3'd2, S_MUL_I = 3'd3,
    S_MUL_D = 3'd4, S_SAT = 3'd5, S_DONE  = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    tick_q, tick_d, busy_q, busy_d, valid_q, valid_d;
  logic [1:0]              mode_q, mode_d;
  logic signed [WIDTH-1:0] e_q, e_d, dv_q, dv_d, sp_q, sp_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [WIDTH-1:0] integ_q [CHANNELS];
  logic signed [WIDTH-1:0] integ_d [CHANNELS];
  logic signed [WIDTH-1:0] eprev_q [CHANNELS];
  logic signed [WIDTH-1:0] eprev_d [CHANNELS];
  logic signed [WIDTH-1:0] duty_q  [CHANNELS];
  logic signed [WIDTH-1:0] duty_d  [CHANNELS];
  logic [1:0]              sat_q   [CHANNELS];  // {clamped high, clamped low}
  logic [1:0]              sat_d   [CHANNELS];

  logic signed [WIDTH-1:0]   sp_s, st_s, e_s, d_s, inew_s, ilim_s, plim_s, dband_s;
  logic signed [WIDTH-1:0]   mul_a_s, mul_b_s;
  logic signed [W1-1:0]      diff_s, esh_s, isum_s, dsub_s, ilim_x_s, plim_w_s, sp_x_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [AW-1:0]      prod_x_s, r_s, db_x_s, pl_x_s;
  logic [1:0]                mode_in_s;
  logic                      hold_s;

  // Rate divider, FSM sequencing and registered strobes.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d  = (cnt_q == CNT_W'(TICK_DIV - 1));
    busy_d  = tick_q | (state_q != S_IDLE);
    valid_d = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (tick_q) begin
          state_d = S_ERR;
          ch_d    = {CH_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR:   state_d = S_MUL_P;
      S_MUL_P: state_d = S_MUL_I;
      S_MUL_I: state_d = S_MUL_D;
      S_MUL_D: state_d = S_SAT;
      S_SAT: begin
        if (ch_q == CH_W'(CHANNELS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERR;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Error, integral, derivative, shared multiplier and output saturation datapath.
  always_comb begin
    sp_s      = bus.setpoint[int'(ch_q)*WIDTH +: WIDTH];
    st_s      = bus.state[int'(ch_q)*WIDTH +: WIDTH];
    mode_in_s = bus.mode[int'(ch_q)*2 +: 2];
    ilim_s    = non_neg(bus.IntegralLimit);
    plim_s    = non_neg(bus.PWMLimit);
    dband_s   = non_neg(bus.deadband);

    diff_s = $signed({sp_s[WIDTH-1], sp_s}) - $signed({st_s[WIDTH-1], st_s});
    esh_s  = diff_s >>> ERR_SHIFT;
    e_s    = sat_w(esh_s);
    hold_s = (sat_q[ch_q][1] & ~e_s[WIDTH-1] & (|e_s)) | (sat_q[ch_q][0] & e_s[WIDTH-1]);

    isum_s   = $signed({integ_q[ch_q][WIDTH-1], integ_q[ch_q]}) + $signed({e_s[WIDTH-1], e_s});
    ilim_x_s = $signed({1'b0, ilim_s});
    if (isum_s > ilim_x_s) begin
      inew_s = ilim_s;
    end else if (isum_s < -ilim_x_s) begin
      inew_s = -ilim_s;
    end else begin
      inew_s = isum_s[WIDTH-1:0];
    end
    dsub_s = $signed({e_s[WIDTH-1], e_s}) - $signed({eprev_q[ch_q][WIDTH-1], eprev_q[ch_q]});
    d_s    = sat_w(dsub_s);

    case (state_q)
      S_MUL_I: begin mul_a_s = bus.Ki; mul_b_s = integ_q[ch_q]; end
      S_MUL_D: begin mul_a_s = bus.Kd; mul_b_s = dv_q; end
      default: begin mul_a_s = bus.Kp; mul_b_s = e_q; end
    endcase
    prod_s   = $signed({{WIDTH{mul_a_s[WIDTH-1]}}, mul_a_s}) * $signed({{WIDTH{mul_b_s[WIDTH-1]}}, mul_b_s});
    prod_x_s = $signed({{2{prod_s[2*WIDTH-1]}}, prod_s});

    r_s      = acc_q >>> GAIN_SHIFT;
    db_x_s   = $signed({{(AW-WIDTH){1'b0}}, dband_s});
    pl_x_s   = $signed({{(AW-WIDTH){1'b0}}, plim_s});
    plim_w_s = $signed({1'b0, plim_s});
    sp_x_s   = $signed({sp_q[WIDTH-1], sp_q});

    mode_d  = mode_q;
    sp_d    = sp_q;
    e_d     = e_q;
    dv_d    = dv_q;
    acc_d   = acc_q;
    integ_d = integ_q;
    eprev_d = eprev_q;
    duty_d  = duty_q;
    sat_d   = sat_q;

    case (state_q)
      S_ERR: begin
        mode_d = mode_in_s;
        sp_d   = sp_s;
        if (mode_in_s == 2'd1) begin
          e_d           = e_s;
          dv_d          = d_s;
          eprev_d[ch_q] = e_s;
          if (hold_s) begin
            integ_d[ch_q] = integ_q[ch_q];
          end else begin
            integ_d[ch_q] = inew_s;
          end
        end else begin
          e_d           = {WIDTH{1'b0}};
          dv_d          = {WIDTH{1'b0}};
          integ_d[ch_q] = {WIDTH{1'b0}};
          eprev_d[ch_q] = {WIDTH{1'b0}};
          sat_d[ch_q]   = 2'b00;
        end
      end
      S_MUL_P: acc_d = prod_x_s;
      S_MUL_I: acc_d = acc_q + prod_x_s;
      S_MUL_D: acc_d = acc_q + prod_x_s;
      S_SAT: begin
        sat_d[ch_q] = 2'b00;
        if (mode_q == 2'd1) begin
          if ((r_s <= db_x_s) && (r_s >= -db_x_s)) begin
            duty_d[ch_q] = {WIDTH{1'b0}};
          end else if (r_s > pl_x_s) begin
            duty_d[ch_q] = plim_s;
            sat_d[ch_q]  = 2'b10;
          end else if (r_s < -pl_x_s) begin
            duty_d[ch_q] = -plim_s;
            sat_d[ch_q]  = 2'b01;
          end else begin
            duty_d[ch_q] = r_s[WIDTH-1:0];
          end
        end else if (mode_q == 2'd2) begin
          if (sp_x_s > plim_w_s) begin
            duty_d[ch_q] = plim_s;
          end else if (sp_x_s < -plim_w_s) begin
            duty_d[ch_q] = -plim_s;
          end else begin
            duty_d[ch_q] = sp_q;
          end
        end else begin
          duty_d[ch_q] = {WIDTH{1'b0}};
        end
      end
      default: acc_d = acc_q;
    endcase
  end

  // State and datapath registers; reset aborts any sweep in progress.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ch_q    <= {CH_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      mode_q  <= 2'b00;
      sp_q    <= {WIDTH{1'b0}};
      e_q     <= {WIDTH{1'b0}};
      dv_q    <= {WIDTH{1'b0}};
      acc_q   <= {AW{1'b0}};
      for (int k = 0; k < CHANNELS; k++) begin
        integ_q[k] <= {WIDTH{1'b0}};
        eprev_q[k] <= {WIDTH{1'b0}};
        duty_q[k]  <= {WIDTH{1'b0}};
        sat_q[k]   <= 2'b00;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      sp_q    <= sp_d;
      e_q     <= e_d;
      dv_q    <= dv_d;
      acc_q   <= acc_d;
      integ_q <= integ_d;
      eprev_q <= eprev_d;
      duty_q  <= duty_d;
      sat_q   <= sat_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_duty
    assign bus.duty[k*WIDTH +: WIDTH] = duty_q[k];
  end
  assign bus.duty_valid = valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_pid_controller_mc.sv
// Directed-vector bench for pid_controller_mc: 2 channels, 16-cycle control period.
module tb_pid_controller_mc;
  localparam int W    = 24;
  localparam int CH   = 2;
  localparam int TDIV = 16;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  pid_controller_mc_if #(.WIDTH(W), .CHANNELS(CH)) pif ();

  pid_controller_mc #(
    .WIDTH(W), .CHANNELS(CH), .CLOCK_FREQ(16000), .CONTROL_FREQ(1000),
    .ERR_SHIFT(4), .GAIN_SHIFT(0)
  ) dut (
    .CLK    (CLK),
    .reset_n(reset_n),
    .bus    (pif.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic signed [W-1:0] duty0_s, duty1_s;
  assign duty0_s = pif.duty[W-1:0];
  assign duty1_s = pif.duty[2*W-1:W];

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_gains(input int kp, input int ki, input int kd, input int plim, input int ilim, input int db);
    pif.Kp = W'(kp); pif.Ki = W'(ki); pif.Kd = W'(kd);
    pif.PWMLimit = W'(plim); pif.IntegralLimit = W'(ilim); pif.deadband = W'(db);
  endtask

  // Error e is produced by setpoint = 16*e against a zero position.
  task automatic set_err(input int ch, input int e, input logic [1:0] m);
    pif.setpoint[ch*W +: W] = W'(e * 16);
    pif.state[ch*W +: W]    = {W{1'b0}};
    pif.mode[ch*2 +: 2]     = m;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (pif.busy) nbusy++;
    end while (!pif.duty_valid && cyc < 64);
    check_eq("valid_seen", 32'(pif.duty_valid), 32'sd1);
  endtask

  task automatic sweep(input string tag, input int exp0);
    int c, b;
    wait_valid(c, b);
    check_eq(tag, 32'(duty0_s), 32'(exp0));
  endtask

  initial begin
    int c, b;
    pif.setpoint = '0; pif.state = '0; pif.mode = '0;
    set_gains(0, 0, 0, 1000, 1000, 0);

    // 1: proportional only, period and busy length
    set_gains(2, 0, 0, 1000, 1000, 0);
    set_err(0, 10, 2'd1);
    set_err(1, 0, 2'd0);
    apply_reset();
    check_eq("rst_duty0", 32'(duty0_s), 32'sd0);
    check_eq("rst_duty1", 32'(duty1_s), 32'sd0);
    check_eq("rst_valid", 32'(pif.duty_valid), 32'sd0);
    check_eq("rst_busy", 32'(pif.busy), 32'sd0);
    wait_valid(c, b);
    check_eq("p_duty0", 32'(duty0_s), 32'sd20);
    check_eq("p_duty1_off", 32'(duty1_s), 32'sd0);
    wait_valid(c, b);
    check_eq("valid_period", 32'(c), 32'(TDIV));
    check_eq("busy_cycles", 32'(b), 32'sd12);
    check_eq("p_duty0_again", 32'(duty0_s), 32'sd20);

    // 2: integral clamp
    set_gains(0, 1, 0, 1000, 25, 0);
    set_err(0, 10, 2'd1);
    apply_reset();
    sweep("i_t1", 10);
    sweep("i_t2", 20);
    sweep("i_t3", 25);
    sweep("i_t4", 25);
    set_err(0, -10, 2'd1);
    sweep("i_neg", 15);

    // 3: deadband
    set_gains(1, 0, 0, 1000, 1000, 5);
    set_err(0, 3, 2'd1);
    apply_reset();
    sweep("db_e3", 0);
    set_err(0, -5, 2'd1);
    sweep("db_em5", 0);
    set_err(0, -6, 2'd1);
    sweep("db_em6", -6);

    // 4: anti-windup
    set_gains(0, 100, 0, 500, 1000, 0);
    set_err(0, 10, 2'd1);
    apply_reset();
    sweep("aw_t1", 500);
    sweep("aw_t2", 500);
    set_err(0, -10, 2'd1);
    sweep("aw_t3", 0);

    // 5: derivative
    set_gains(0, 0, 3, 1000, 1000, 0);
    set_err(0, 0, 2'd1);
    apply_reset();
    sweep("d_t1", 0);
    set_err(0, 10, 2'd1);
    sweep("d_t2", 30);
    sweep("d_t3", 0);

    // 6: direct mode, off mode, reset mid-sweep
    set_gains(2, 0, 0, 500, 1000, 0);
    set_err(0, 10, 2'd1);
    pif.setpoint[W +: W] = -24'sd700;
    pif.state[W +: W]    = 24'sd0;
    pif.mode[3:2]        = 2'd2;
    apply_reset();
    wait_valid(c, b);
    check_eq("dir_duty1", 32'(duty1_s), -32'sd500);
    check_eq("dir_duty0", 32'(duty0_s), 32'sd20);
    pif.mode[3:2] = 2'd0;
    wait_valid(c, b);
    check_eq("off_duty1", 32'(duty1_s), 32'sd0);
    check_eq("off_duty0", 32'(duty0_s), 32'sd20);
    c = 0;
    do begin
      @(negedge CLK);
      c++;
    end while (!pif.busy && c < 64);
    check_eq("busy_seen", 32'(pif.busy), 32'sd1);
    repeat (7) @(negedge CLK);
    reset_n = 1'b0;
    #1;
    check_eq("abort_duty0", 32'(duty0_s), 32'sd0);
    check_eq("abort_duty1", 32'(duty1_s), 32'sd0);
    check_eq("abort_valid", 32'(pif.duty_valid), 32'sd0);
    check_eq("abort_busy", 32'(pif.busy), 32'sd0);
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    wait_valid(c, b);
    check_eq("first_valid_lat", 32'(c), 32'(TDIV + 12));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
